router_input_fifo: RTL and testbench

- Per-port input buffer of the 5-port NoC router; sits directly upstream of the per-output Arbiter and the crossbar.
- Accepts flits from the neighbouring router (or local PE) over the two-phase RTS/CTS link handshake that the Arbiter drives on its output side.
- Holds them in a small circular buffer and presents the head flit first-word-fall-through to the routing logic and crossbar.
- Pops the head flit when any output Arbiter grants this input port.

---
 rtl/router_input_fifo.sv | 105 ++++++++++
 tb/tb_router_input_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/router_input_fifo.sv
// Per-port NoC router input buffer: two-phase RTS/CTS link handshake in, first-word-fall-through head flit out.
// Define ROUTER_FIFO_ERR_CHECK_EN to add a sticky grant-protocol error output (err).
module router_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    output logic                  CTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full
`ifdef ROUTER_FIFO_ERR_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  cts_q, cts_d;
    logic [4:0]            grants;
    logic                  writeEn;
    logic                  readEn;

    assign grants   = {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L};
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    // The !full term only matters if a write is forced while full; it is dropped.
    assign writeEn  = DRTS & cts_q & ~full;
    assign readEn   = (|grants) & ~empty;
    assign CTS      = cts_q;
    assign Data_out = mem_q[rdPtr_q];

    always_comb begin
        cts_d   = DRTS & ~cts_q & ~full;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (writeEn) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (readEn) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
        if (writeEn && !readEn) begin
            count_d = count_q + CNT_ONE;
        end else if (readEn && !writeEn) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cts_q   <= 1'b0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            cts_q   <= cts_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem_q[wrPtr_q] <= RX;
        end
    end

`ifdef ROUTER_FIFO_ERR_CHECK_EN
    logic err_q;
    logic errSet;

    assign errSet = ~$onehot0(grants) | ((|grants) & empty);
    assign err    = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (errSet) begin
            err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_router_input_fifo.sv
// Bench for router_input_fifo: vector table plus scoreboard of written flits checked in FIFO order.
// Also covers the err output when ROUTER_FIFO_ERR_CHECK_EN is defined.
module tb_router_input_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [4:0] G_NONE = 5'b00000;
    localparam logic [4:0] G_N    = 5'b10000;
    localparam logic [4:0] G_E    = 5'b01000;
    localparam logic [4:0] G_S    = 5'b00010;
    localparam logic [4:0] G_L    = 5'b00001;

    logic          clk;
    logic          rst;
    logic [DW-1:0] RX;
    logic          DRTS;
    logic          CTS;
    logic [4:0]    grants;
    logic [DW-1:0] Data_out;
    logic          empty;
    logic          full;
`ifdef ROUTER_FIFO_ERR_CHECK_EN
    logic          err;
`endif

    router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .DRTS      (DRTS),
        .CTS       (CTS),
        .read_en_N (grants[4]),
        .read_en_E (grants[3]),
        .read_en_W (grants[2]),
        .read_en_S (grants[1]),
        .read_en_L (grants[0]),
        .Data_out  (Data_out),
        .empty     (empty),
        .full      (full)
`ifdef ROUTER_FIFO_ERR_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          drts;
        logic [DW-1:0] rx;
        logic [4:0]    grants;
        logic          expCts;
        logic          expEmpty;
        logic          expFull;
    } vec_t;

    vec_t          vecs [18];
    logic [DW-1:0] sb [$];
    logic          mCts;
    int            mCount;
    logic          lastWrite;
    logic [DW-1:0] nextRx;
    int            total;
    int            bad;

    task automatic compare(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, "_cts"}, DW'(CTS), DW'(mCts));
        compare({tag, "_empty"}, DW'(empty), DW'(mCount == 0));
        compare({tag, "_full"}, DW'(full), DW'(mCount == DEPTH));
        if (sb.size() > 0) begin
            compare({tag, "_head"}, Data_out, sb[0]);
        end
    endtask

    // Drive one cycle at a negedge, advance the model across the posedge, check at the next negedge.
    task automatic applyStimulus(input logic drts, input logic [DW-1:0] rx, input logic [4:0] g);
        logic wr, rd, ctsNext;
        logic [DW-1:0] expData;
        DRTS    = drts;
        RX      = rx;
        grants  = g;
        wr      = drts && mCts && (mCount != DEPTH);
        rd      = (g != 5'b0) && (mCount != 0);
        ctsNext = drts && !mCts && (mCount != DEPTH);
        if (rd) begin
            expData = sb.pop_front();
            compare("pop_data", Data_out, expData);
        end
        @(posedge clk);
        if (wr) sb.push_back(rx);
        if (wr && !rd) mCount++;
        if (rd && !wr) mCount--;
        mCts      = ctsNext;
        lastWrite = wr;
        @(negedge clk);
        checkOutput("cyc");
    endtask

    task automatic pushFlits(input int n);
        int got;
        got = 0;
        for (int c = 0; c < 4 * n + 4 && got < n; c++) begin
            applyStimulus(1'b1, nextRx, G_NONE);
            if (lastWrite) begin
                got++;
                nextRx++;
            end
        end
        compare("push_budget", DW'(got), DW'(n));
    endtask

    task automatic drainN(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, G_E);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        DRTS   = 1'b0;
        RX     = '0;
        grants = G_NONE;
        mCts   = 1'b0;
        mCount = 0;
        nextRx = 32'hB0;

        // Fill to full at one flit per two cycles, pop once, then exercise simultaneous write/read and empty read.
        vecs[0]  = '{1'b1, 32'hA0, G_NONE, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'hA0, G_NONE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'hA1, G_NONE, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'hA1, G_NONE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'hA2, G_NONE, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'hA2, G_NONE, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'hA3, G_NONE, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'hA3, G_NONE, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 32'hA4, G_NONE, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'hA4, G_NONE, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 32'hA4, G_E,    1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'hA4, G_NONE, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'hA4, G_N,    1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'hA4, G_NONE, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 32'hA4, G_S,    1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 32'h00, G_L,    1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 32'h00, G_L,    1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 32'h00, G_L,    1'b0, 1'b1, 1'b0};

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset");
`ifdef ROUTER_FIFO_ERR_CHECK_EN
        compare("reset_err", DW'(err), '0);
`endif
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].drts, vecs[i].rx, vecs[i].grants);
            compare($sformatf("vec%0d_cts", i), DW'(CTS), DW'(vecs[i].expCts));
            compare($sformatf("vec%0d_empty", i), DW'(empty), DW'(vecs[i].expEmpty));
            compare($sformatf("vec%0d_full", i), DW'(full), DW'(vecs[i].expFull));
        end
        compare("after_pop_a1_head_seen", DW'(sb.size()), '0);
`ifdef ROUTER_FIFO_ERR_CHECK_EN
        compare("empty_read_err", DW'(err), 32'd1);
`endif

        // Build count = 3 with CTS high, then reset asynchronously mid-handshake.
        pushFlits(3);
        applyStimulus(1'b1, nextRx, G_NONE);
        compare("pre_reset_cts", DW'(CTS), 32'd1);
        rst = 1'b0;
        #1;
        mCts   = 1'b0;
        mCount = 0;
        sb.delete();
        checkOutput("midreset");
`ifdef ROUTER_FIFO_ERR_CHECK_EN
        compare("midreset_err", DW'(err), '0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Pointer wrap: fill, drain, refill partially, drain again with order preserved.
        pushFlits(DEPTH);
        compare("wrap_full", DW'(full), 32'd1);
        drainN(DEPTH);
        compare("wrap_empty", DW'(empty), 32'd1);
        pushFlits(3);
        compare("wrap_refill_empty", DW'(empty), '0);
        drainN(3);
        compare("wrap_drained", DW'(empty), 32'd1);

`ifdef ROUTER_FIFO_ERR_CHECK_EN
        pushFlits(2);
        applyStimulus(1'b0, '0, G_N | G_E);
        compare("multigrant_err", DW'(err), 32'd1);
        drainN(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
